execute_controller: RTL and testbench
=====================================

EXECUTE_CONTROLLER -- requirements
Module: execute_controller

Interface
REQ-001 Parameter MULT_CYCLES, default 4, execute-stage occupancy in cycles of one MULT; legal range 2..15.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  decode stage presents an instruction.
REQ-005 in_ready  output  1  controller accepts the instruction this cycle; combinational.
REQ-006 opcode  input  6  MIPS opcode field.
REQ-007 funct  input  6  MIPS funct field, used when opcode = 000000.
REQ-008 stall_in  input  1  downstream hold; freezes all registered outputs.
REQ-009 flush  input  1  discards the held and in-flight instruction.
REQ-010 ex_valid  output  1  control word below is valid for the execute stage this cycle.
REQ-011 sel  output  1  ALU operand-B select: 0 = registro_2, 1 = sign_extend.
REQ-012 alu_op  output  3  0 AND, 1 OR, 2 ADD, 3 MULT-result, 6 SUB, 7 SLT.
REQ-013 mem_read, mem_write, reg_write  output  1 each  forwarded memory and writeback controls.
REQ-014 mult_start  output  1  one-cycle start pulse to the multiplier.
REQ-015 busy  output  1  high while in state MULT.
REQ-016 illegal  output  1  one-cycle pulse when an undecodable instruction is accepted.
REQ-017 issue_count  output  16  number of control words issued (ex_valid cycles), wraps 0xFFFF -> 0x0000.

Function
REQ-018 States: IDLE (no valid word), ISSUE (word valid), MULT (multiply in progress).
REQ-019 in_ready = !stall_in && state != MULT; an instruction is accepted when in_valid && in_ready.
REQ-020 Decode latency: exactly one cycle from acceptance to ex_valid, except MULT.
REQ-021 Decode: funct 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 101010 SLT; all with sel=0, reg_write=1.
REQ-022 Decode: addi 001000 -> ADD, sel=1, reg_write=1; lw 100011 -> ADD, sel=1, mem_read=1, reg_write=1.
REQ-023 Decode: sw 101011 -> ADD, sel=1, mem_write=1; beq 000100 -> SUB, sel=0, no writes.
REQ-024 Any other encoding: ex_valid=0, all controls 0, illegal=1 for one cycle, state -> IDLE.
REQ-025 Accept with no new valid instruction: ISSUE -> IDLE, ex_valid=0, controls 0.
REQ-026 Back-to-back accepts stay in ISSUE with ex_valid=1 every cycle.
REQ-027 stall_in high: all outputs and state hold, counter in MULT still decrements; MULT completion during stall is held until stall_in low.
REQ-028 flush: next cycle ex_valid=0, all controls 0, mult_start=0, state IDLE; the instruction presented with flush is not accepted.
REQ-029 Priority: reset > flush > stall_in > accept.
REQ-030 issue_count increments on every cycle where ex_valid=1 and stall_in=0.

Reset
REQ-031 On reset: state IDLE; ex_valid, sel, alu_op, mem_read, mem_write, reg_write, mult_start, busy, illegal all 0; issue_count 0.
REQ-032 Reset mid-MULT aborts the multiply with no ex_valid produced.

Configuration
REQ-033 Macro EXEC_CTRL_MULT_EN: defined -> funct 011000 accepted, mult_start pulses next cycle, state MULT for MULT_CYCLES cycles with busy=1 and ex_valid=0, then one cycle ex_valid=1, alu_op=3, reg_write=1, sel=0.
REQ-034 Macro undefined -> funct 011000 is illegal per REQ-024; state MULT, busy and mult_start are permanently 0.

Verification
REQ-035 Reset, then ADD (000000/100000) -> next cycle ex_valid=1, sel=0, alu_op=2, reg_write=1, issue_count=1.
REQ-036 lw then sw back-to-back -> two consecutive ex_valid cycles: (sel=1, mem_read=1, reg_write=1) then (sel=1, mem_write=1, reg_write=0).
REQ-037 MULT with EXEC_CTRL_MULT_EN, MULT_CYCLES=4 -> mult_start cycle 1, busy cycles 1-4, in_ready=0, ex_valid with alu_op=3 at cycle 5.
REQ-038 flush asserted at MULT cycle 2 -> busy drops next cycle, no ex_valid, issue_count unchanged.
REQ-039 opcode 111111 accepted -> illegal pulse one cycle, ex_valid=0; with stall_in held 3 cycles after an ADD, outputs frozen and issue_count advances by exactly 1.
REQ-040 Issue 65536 instructions -> issue_count wraps to 0x0000.

Source files
------------

// File: rtl/execute_controller.sv
// Execute-stage controller: decodes MIPS opcode/funct into ALU and memory controls.
// Optional multi-cycle MULT support is enabled by defining EXEC_CTRL_MULT_EN.
module execute_controller #(
  parameter int MULT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        stall_in,
  input  logic        flush,
  output logic        ex_valid,
  output logic        sel,
  output logic [2:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mult_start,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] issue_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, MULT} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        ex_valid_nx, sel_nx, mem_read_nx, mem_write_nx, reg_write_nx;
  logic        mult_start_nx, illegal_nx;
  logic [2:0]  alu_op_nx;
  logic        dec_ok, dec_mult, dec_sel, dec_mr, dec_mw, dec_rw;
  logic [2:0]  dec_op;
  logic        accept;

  assign in_ready = !stall_in && (state != MULT);
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = (state == MULT);

  always_comb begin
    dec_ok   = 1'b0;
    dec_mult = 1'b0;
    dec_sel  = 1'b0;
    dec_op   = 3'd0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_rw   = 1'b0;
    if (opcode == 6'b000000) begin
      case (funct)
        6'b100000: begin dec_ok = 1'b1; dec_op = 3'd2; dec_rw = 1'b1; end
        6'b100010: begin dec_ok = 1'b1; dec_op = 3'd6; dec_rw = 1'b1; end
        6'b100100: begin dec_ok = 1'b1; dec_op = 3'd0; dec_rw = 1'b1; end
        6'b100101: begin dec_ok = 1'b1; dec_op = 3'd1; dec_rw = 1'b1; end
        6'b101010: begin dec_ok = 1'b1; dec_op = 3'd7; dec_rw = 1'b1; end
`ifdef EXEC_CTRL_MULT_EN
        6'b011000: begin dec_ok = 1'b1; dec_mult = 1'b1; end
`endif
        default:   dec_ok = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'b001000: begin dec_ok = 1'b1; dec_op = 3'd2; dec_sel = 1'b1; dec_rw = 1'b1; end
        6'b100011: begin
          dec_ok = 1'b1; dec_op = 3'd2; dec_sel = 1'b1; dec_mr = 1'b1; dec_rw = 1'b1;
        end
        6'b101011: begin dec_ok = 1'b1; dec_op = 3'd2; dec_sel = 1'b1; dec_mw = 1'b1; end
        6'b000100: begin dec_ok = 1'b1; dec_op = 3'd6; end
        default:   dec_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ex_valid_nx   = ex_valid;
    sel_nx        = sel;
    alu_op_nx     = alu_op;
    mem_read_nx   = mem_read;
    mem_write_nx  = mem_write;
    reg_write_nx  = reg_write;
    mult_start_nx = mult_start;
    illegal_nx    = illegal;
    if (flush || (!stall_in && state != MULT)) begin
      state_nx      = IDLE;
      cnt_nx        = 4'd0;
      ex_valid_nx   = 1'b0;
      sel_nx        = 1'b0;
      alu_op_nx     = 3'd0;
      mem_read_nx   = 1'b0;
      mem_write_nx  = 1'b0;
      reg_write_nx  = 1'b0;
      mult_start_nx = 1'b0;
      illegal_nx    = 1'b0;
      if (accept) begin
        if (dec_ok && dec_mult) begin
          state_nx      = MULT;
          mult_start_nx = 1'b1;
          cnt_nx        = 4'(MULT_CYCLES - 1);
        end else if (dec_ok) begin
          state_nx     = ISSUE;
          ex_valid_nx  = 1'b1;
          sel_nx       = dec_sel;
          alu_op_nx    = dec_op;
          mem_read_nx  = dec_mr;
          mem_write_nx = dec_mw;
          reg_write_nx = dec_rw;
        end else begin
          illegal_nx = 1'b1;
        end
      end
    end else if (stall_in) begin
      // The multiply keeps counting under stall; only its completion waits.
      if (state == MULT && cnt != 4'd0) cnt_nx = cnt - 4'd1;
    end else begin
      mult_start_nx = 1'b0;
      if (cnt == 4'd0) begin
        state_nx     = ISSUE;
        ex_valid_nx  = 1'b1;
        sel_nx       = 1'b0;
        alu_op_nx    = 3'd3;
        reg_write_nx = 1'b1;
      end else begin
        cnt_nx = cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ex_valid    <= 1'b0;
      sel         <= 1'b0;
      alu_op      <= 3'd0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      reg_write   <= 1'b0;
      mult_start  <= 1'b0;
      illegal     <= 1'b0;
      issue_count <= 16'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ex_valid    <= ex_valid_nx;
      sel         <= sel_nx;
      alu_op      <= alu_op_nx;
      mem_read    <= mem_read_nx;
      mem_write   <= mem_write_nx;
      reg_write   <= reg_write_nx;
      mult_start  <= mult_start_nx;
      illegal     <= illegal_nx;
      if (ex_valid && !stall_in) issue_count <= issue_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_execute_controller.sv
// Directed bench for execute_controller; MULT steps follow the EXEC_CTRL_MULT_EN build.
module tb_execute_controller;

  logic        clock = 1'b0;
  logic        reset, in_valid, stall_in, flush;
  logic [5:0]  opcode, funct;
  logic        in_ready, ex_valid, sel, mem_read, mem_write, reg_write;
  logic        mult_start, busy, illegal;
  logic [2:0]  alu_op;
  logic [15:0] issue_count;
  int          checks = 0;
  int          errors = 0;

  execute_controller #(.MULT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .sel(sel), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mult_start(mult_start),
    .busy(busy), .illegal(illegal), .issue_count(issue_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {sel, alu_op, mem_read, mem_write, reg_write}
  function automatic logic [31:0] word();
    return {25'd0, sel, alu_op, mem_read, mem_write, reg_write};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
    in_valid = v;
    opcode   = op;
    funct    = fn;
  endtask

  logic [5:0] t_op [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000100};
  logic [5:0] t_fn [6] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000000};
  logic [6:0] t_w  [6] = '{7'b0110001, 7'b0000001, 7'b0001001, 7'b0111001, 7'b1010001, 7'b0110000};

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
    drive(1'b0, 6'd0, 6'd0);
    step(); step();
    reset = 1'b0;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_word", word(), 0);
    check("rst_flags", {mult_start, busy, illegal}, 0);
    check("rst_count", issue_count, 0);
    check("rst_in_ready", in_ready, 1);

    drive(1'b1, 6'b000000, 6'b100000);
    step();
    drive(1'b0, 6'd0, 6'd0);
    check("add_ex_valid", ex_valid, 1);
    check("add_word", word(), 32'b0010001);
    step();
    check("add_idle_ex_valid", ex_valid, 0);
    check("add_count", issue_count, 1);

    drive(1'b1, 6'b100011, 6'd0);
    step();
    check("lw_ex_valid", ex_valid, 1);
    check("lw_word", word(), 32'b1010101);
    drive(1'b1, 6'b101011, 6'd0);
    step();
    drive(1'b0, 6'd0, 6'd0);
    check("sw_ex_valid", ex_valid, 1);
    check("sw_word", word(), 32'b1010010);
    step();
    check("lwsw_idle", ex_valid, 0);
    check("lwsw_count", issue_count, 3);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t_op[i], t_fn[i]);
      step();
      check($sformatf("dec%0d_ex_valid", i), ex_valid, 1);
      check($sformatf("dec%0d_word", i), word(), {25'd0, t_w[i]});
    end
    drive(1'b0, 6'd0, 6'd0);
    step();
    check("dec_count", issue_count, 9);

    drive(1'b1, 6'b111111, 6'd0);
    step();
    drive(1'b0, 6'd0, 6'd0);
    check("ill_pulse", illegal, 1);
    check("ill_ex_valid", ex_valid, 0);
    check("ill_word", word(), 0);
    step();
    check("ill_clear", illegal, 0);
    check("ill_count", issue_count, 9);

    drive(1'b1, 6'b000000, 6'b100000);
    step();
    drive(1'b1, 6'b101011, 6'd0);
    stall_in = 1'b1;
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_ex_valid", i), ex_valid, 1);
      check($sformatf("stall%0d_word", i), word(), 32'b0010001);
      check($sformatf("stall%0d_count", i), issue_count, 9);
    end
    stall_in = 1'b0;
    drive(1'b0, 6'd0, 6'd0);
    step();
    check("stall_count", issue_count, 10);
    check("stall_release", ex_valid, 0);

    drive(1'b1, 6'b000000, 6'b100000);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 6'd0, 6'd0);
    check("flush_ex_valid", ex_valid, 0);
    check("flush_word", word(), 0);
    step();
    check("flush_not_accepted", ex_valid, 0);
    check("flush_count", issue_count, 11);

`ifdef EXEC_CTRL_MULT_EN
    drive(1'b1, 6'b000000, 6'b011000);
    step();
    drive(1'b1, 6'b000000, 6'b100000);
    check("mul_c1_start", mult_start, 1);
    check("mul_c1_busy", busy, 1);
    check("mul_c1_ready", in_ready, 0);
    check("mul_c1_ex_valid", ex_valid, 0);
    step();
    check("mul_c2_start", mult_start, 0);
    check("mul_c2_busy", busy, 1);
    step();
    check("mul_c3_busy", busy, 1);
    step();
    check("mul_c4_busy", busy, 1);
    check("mul_c4_ex_valid", ex_valid, 0);
    drive(1'b0, 6'd0, 6'd0);
    step();
    check("mul_c5_ex_valid", ex_valid, 1);
    check("mul_c5_word", word(), 32'b0011001);
    check("mul_c5_busy", busy, 0);
    step();
    check("mul_count", issue_count, 12);

    drive(1'b1, 6'b000000, 6'b011000);
    step();
    drive(1'b0, 6'd0, 6'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mflush_busy", busy, 0);
    check("mflush_ex_valid", ex_valid, 0);
    check("mflush_start", mult_start, 0);
    step();
    check("mflush_no_issue", ex_valid, 0);
    check("mflush_count", issue_count, 12);

    drive(1'b1, 6'b000000, 6'b011000);
    step();
    drive(1'b0, 6'd0, 6'd0);
    stall_in = 1'b1;
    repeat (5) step();
    check("mstall_busy", busy, 1);
    check("mstall_ex_valid", ex_valid, 0);
    stall_in = 1'b0;
    step();
    check("mstall_done", ex_valid, 1);
    check("mstall_word", word(), 32'b0011001);

    drive(1'b1, 6'b000000, 6'b011000);
    step();
    drive(1'b0, 6'd0, 6'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_busy", busy, 0);
    step();
    check("mrst_ex_valid", ex_valid, 0);
`else
    drive(1'b1, 6'b000000, 6'b011000);
    step();
    drive(1'b0, 6'd0, 6'd0);
    check("nomul_illegal", illegal, 1);
    check("nomul_ex_valid", ex_valid, 0);
    check("nomul_flags", {mult_start, busy}, 0);
    step();
    check("nomul_busy", busy, 0);
    check("nomul_count", issue_count, 11);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif
    check("wrap_start", issue_count, 0);

    drive(1'b1, 6'b000000, 6'b100000);
    repeat (65536) step();
    drive(1'b0, 6'd0, 6'd0);
    check("wrap_ffff", issue_count, 16'hFFFF);
    step();
    check("wrap_zero", issue_count, 0);
    check("wrap_idle", ex_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
